// File: rtl/multicycle_controller.sv
// Control FSM for the shared-memory multicycle MIPS datapath: decodes op/funct and
// emits per-cycle selects and strobes, with a bounded wait on the memory handshake.
module multicycle_controller #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_timeout
);

    localparam int unsigned CW = 8;
    localparam bit            TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] WAIT_LAST  = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    state_t        state_r, state_n;
    logic [CW-1:0] cnt_r, cnt_n;
    logic          waiting;

    // State and memory-wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    assign state = state_r;

    // Next state and per-cycle control outputs
    always_comb begin
        state_n     = S_FETCH;
        cnt_n       = '0;
        waiting     = 1'b0;
        iord        = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        pcen        = 1'b0;
        alucontrol  = ALU_ADD;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        mem_timeout = 1'b0;

        case (state_r)
            S_FETCH: begin
                waiting = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
                state_n = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_RTYPE:     state_n = S_EXECUTE;
                    OP_BEQ:       state_n = S_BRANCH;
                    OP_ADDI:      state_n = S_ADDIEXEC;
                    OP_J:         state_n = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_n = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                waiting = 1'b1;
                iord    = 1'b1;
                state_n = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                waiting    = 1'b1;
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = mem_ready;
                state_n    = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                state_n = S_ALUWB;
                case (funct)
                    6'b100000: alucontrol = ALU_ADD;
                    6'b100010: alucontrol = ALU_SUB;
                    6'b100100: alucontrol = ALU_AND;
                    6'b100101: alucontrol = ALU_OR;
                    6'b101010: alucontrol = ALU_SLT;
                    default: begin
                        illegal = 1'b1;
                        state_n = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = zero;
                instr_done = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_n = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcen       = 1'b1;
                instr_done = 1'b1;
            end
            default: state_n = S_FETCH;
        endcase

        // A completing handshake beats an expiring wait in the same cycle
        if (TIMEOUT_EN && waiting && !mem_ready && (cnt_r == WAIT_LAST)) begin
            mem_timeout = 1'b1;
            state_n     = S_FETCH;
        end

        if (waiting && !mem_ready && !mem_timeout && (state_n == state_r))
            cnt_n = cnt_r + CW'(1);

        if (reset) begin
            pcen        = 1'b0;
            irwrite     = 1'b0;
            memwrite    = 1'b0;
            regwrite    = 1'b0;
            instr_done  = 1'b0;
            illegal     = 1'b0;
            mem_timeout = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller: each row gives one cycle's
// inputs with the hand-derived state and control word expected in that cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b100011;
    logic [5:0] funct = 6'b100000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       instr_done, illegal, mem_timeout;

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol),
        .state(state), .instr_done(instr_done), .illegal(illegal),
        .mem_timeout(mem_timeout)
    );

    typedef struct packed {
        logic [6:0] flags;   // iord memwrite irwrite regdst memtoreg regwrite alusrca
        logic [1:0] srcb;
        logic [1:0] pcs;
        logic       pce;
        logic [2:0] alu;
        logic [2:0] pulses;  // instr_done illegal mem_timeout
    } out_t;

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        logic [3:0] st;
        out_t       o;
    } vec_t;

    out_t act;
    assign act = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, pcsrc, pcen, alucontrol, instr_done, illegal, mem_timeout};

    localparam out_t F_R    = {7'b0010000, 2'b01, 2'b00, 1'b1, 3'b010, 3'b000};
    localparam out_t F_NR   = {7'b0000000, 2'b01, 2'b00, 1'b0, 3'b010, 3'b000};
    localparam out_t F_TO   = {7'b0000000, 2'b01, 2'b00, 1'b0, 3'b010, 3'b001};
    localparam out_t DEC    = {7'b0000000, 2'b11, 2'b00, 1'b0, 3'b010, 3'b000};
    localparam out_t DECILL = {7'b0000000, 2'b11, 2'b00, 1'b0, 3'b010, 3'b010};
    localparam out_t MADR   = {7'b0000001, 2'b10, 2'b00, 1'b0, 3'b010, 3'b000};
    localparam out_t MRD    = {7'b1000000, 2'b00, 2'b00, 1'b0, 3'b010, 3'b000};
    localparam out_t MWB    = {7'b0000110, 2'b00, 2'b00, 1'b0, 3'b010, 3'b100};
    localparam out_t MWR_W  = {7'b1100000, 2'b00, 2'b00, 1'b0, 3'b010, 3'b000};
    localparam out_t MWR_D  = {7'b1100000, 2'b00, 2'b00, 1'b0, 3'b010, 3'b100};
    localparam out_t MWR_TO = {7'b1100000, 2'b00, 2'b00, 1'b0, 3'b010, 3'b001};
    localparam out_t EX_ADD = {7'b0000001, 2'b00, 2'b00, 1'b0, 3'b010, 3'b000};
    localparam out_t EX_AND = {7'b0000001, 2'b00, 2'b00, 1'b0, 3'b000, 3'b000};
    localparam out_t EX_OR  = {7'b0000001, 2'b00, 2'b00, 1'b0, 3'b001, 3'b000};
    localparam out_t EX_SLT = {7'b0000001, 2'b00, 2'b00, 1'b0, 3'b111, 3'b000};
    localparam out_t EX_ILL = {7'b0000001, 2'b00, 2'b00, 1'b0, 3'b010, 3'b010};
    localparam out_t ALUWB  = {7'b0001010, 2'b00, 2'b00, 1'b0, 3'b010, 3'b100};
    localparam out_t BR1    = {7'b0000001, 2'b00, 2'b01, 1'b1, 3'b110, 3'b100};
    localparam out_t BR0    = {7'b0000001, 2'b00, 2'b01, 1'b0, 3'b110, 3'b100};
    localparam out_t ADDIX  = {7'b0000001, 2'b10, 2'b00, 1'b0, 3'b010, 3'b000};
    localparam out_t ADDIWB = {7'b0000010, 2'b00, 2'b00, 1'b0, 3'b010, 3'b100};
    localparam out_t JMP    = {7'b0000000, 2'b00, 2'b10, 1'b1, 3'b010, 3'b100};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JOP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic add(input logic rst, input logic [5:0] o, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [3:0] st, input out_t w);
        vecs.push_back({rst, o, fn, z, rdy, st, w});
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s row %0d: got %b want %b", name, row, got, want);
    endtask

    initial begin
        int cycles;
        bit seen;

        // reset cycle: FETCH with ready high but strobes forced low
        add(1, LW, 6'h20, 0, 1, 4'd0, F_NR);
        // lw, ready tied high
        add(0, LW, 6'h20, 0, 1, 4'd0, F_R);   add(0, LW, 6'h20, 0, 1, 4'd1, DEC);
        add(0, LW, 6'h20, 0, 1, 4'd2, MADR);  add(0, LW, 6'h20, 0, 1, 4'd3, MRD);
        add(0, LW, 6'h20, 0, 1, 4'd4, MWB);
        // sw
        add(0, SW, 6'h20, 0, 1, 4'd0, F_R);   add(0, SW, 6'h20, 0, 1, 4'd1, DEC);
        add(0, SW, 6'h20, 0, 1, 4'd2, MADR);  add(0, SW, 6'h20, 0, 1, 4'd5, MWR_D);
        // R-type add
        add(0, RT, 6'b100000, 0, 1, 4'd0, F_R);    add(0, RT, 6'b100000, 0, 1, 4'd1, DEC);
        add(0, RT, 6'b100000, 0, 1, 4'd6, EX_ADD); add(0, RT, 6'b100000, 0, 1, 4'd7, ALUWB);
        // addi
        add(0, ADDI, 6'h20, 0, 1, 4'd0, F_R);   add(0, ADDI, 6'h20, 0, 1, 4'd1, DEC);
        add(0, ADDI, 6'h20, 0, 1, 4'd9, ADDIX); add(0, ADDI, 6'h20, 0, 1, 4'd10, ADDIWB);
        // beq taken / not taken, then j
        add(0, BEQ, 6'h20, 1, 1, 4'd0, F_R); add(0, BEQ, 6'h20, 1, 1, 4'd1, DEC);
        add(0, BEQ, 6'h20, 1, 1, 4'd8, BR1);
        add(0, BEQ, 6'h20, 0, 1, 4'd0, F_R); add(0, BEQ, 6'h20, 0, 1, 4'd1, DEC);
        add(0, BEQ, 6'h20, 0, 1, 4'd8, BR0);
        add(0, JOP, 6'h20, 0, 1, 4'd0, F_R); add(0, JOP, 6'h20, 0, 1, 4'd1, DEC);
        add(0, JOP, 6'h20, 0, 1, 4'd11, JMP);
        // and, or, slt, then an unknown funct
        add(0, RT, 6'b100100, 0, 1, 4'd0, F_R);    add(0, RT, 6'b100100, 0, 1, 4'd1, DEC);
        add(0, RT, 6'b100100, 0, 1, 4'd6, EX_AND); add(0, RT, 6'b100100, 0, 1, 4'd7, ALUWB);
        add(0, RT, 6'b100101, 0, 1, 4'd0, F_R);    add(0, RT, 6'b100101, 0, 1, 4'd1, DEC);
        add(0, RT, 6'b100101, 0, 1, 4'd6, EX_OR);  add(0, RT, 6'b100101, 0, 1, 4'd7, ALUWB);
        add(0, RT, 6'b101010, 0, 1, 4'd0, F_R);    add(0, RT, 6'b101010, 0, 1, 4'd1, DEC);
        add(0, RT, 6'b101010, 0, 1, 4'd6, EX_SLT); add(0, RT, 6'b101010, 0, 1, 4'd7, ALUWB);
        add(0, RT, 6'b111111, 0, 1, 4'd0, F_R);    add(0, RT, 6'b111111, 0, 1, 4'd1, DEC);
        add(0, RT, 6'b111111, 0, 1, 4'd6, EX_ILL);
        // unknown op
        add(0, BAD, 6'h20, 0, 1, 4'd0, F_R); add(0, BAD, 6'h20, 0, 1, 4'd1, DECILL);
        // lw with three wait cycles in MEMRD
        add(0, LW, 6'h20, 0, 1, 4'd0, F_R);  add(0, LW, 6'h20, 0, 1, 4'd1, DEC);
        add(0, LW, 6'h20, 0, 1, 4'd2, MADR);
        for (int i = 0; i < 3; i++) add(0, LW, 6'h20, 0, 0, 4'd3, MRD);
        add(0, LW, 6'h20, 0, 1, 4'd3, MRD);  add(0, LW, 6'h20, 0, 1, 4'd4, MWB);
        // sw that never completes: 15 cycles of memwrite, timeout on the 15th
        add(0, SW, 6'h20, 0, 1, 4'd0, F_R);  add(0, SW, 6'h20, 0, 1, 4'd1, DEC);
        add(0, SW, 6'h20, 0, 1, 4'd2, MADR);
        for (int i = 0; i < 14; i++) add(0, SW, 6'h20, 0, 0, 4'd5, MWR_W);
        add(0, SW, 6'h20, 0, 0, 4'd5, MWR_TO);
        // fetch timeout: PC not advanced, stays in FETCH
        for (int i = 0; i < 14; i++) add(0, RT, 6'b100000, 0, 0, 4'd0, F_NR);
        add(0, RT, 6'b100000, 0, 0, 4'd0, F_TO);
        // ready on the would-be timeout cycle wins
        for (int i = 0; i < 14; i++) add(0, RT, 6'b100000, 0, 0, 4'd0, F_NR);
        add(0, RT, 6'b100000, 0, 1, 4'd0, F_R);
        add(0, RT, 6'b100000, 0, 1, 4'd1, DEC);
        // reset during EXECUTE abandons the instruction
        add(1, RT, 6'b100000, 0, 1, 4'd6, EX_ADD);
        add(0, RT, 6'b100000, 0, 1, 4'd0, F_R);
        add(0, RT, 6'b100000, 0, 1, 4'd1, DEC);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst;
            op        = vecs[i].op;
            funct     = vecs[i].fn;
            zero      = vecs[i].z;
            mem_ready = vecs[i].rdy;
            @(negedge clk);
            chk("state", i, 32'(state), 32'(vecs[i].st));
            chk("ctrl", i, 32'(act), 32'(vecs[i].o));
            @(posedge clk);
            #1;
        end

        // lw from reset release retires in exactly five cycles
        reset = 1'b1; op = LW; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < 20) begin
            @(negedge clk);
            cycles++;
            seen = instr_done;
            if (!seen) begin
                @(posedge clk);
                #1;
            end
        end
        chk("lw_cycles", 0, 32'(cycles), 32'd5);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("done_once", 0, 32'({instr_done, state}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
